// File: rtl/mseq_generator.sv
// Maximal-length sequence (m-sequence) chip generator.
// A Fibonacci LFSR of order 4..12 maps each chip bit to one of two amplitudes.
module mseq_generator #(
  parameter int OUTPUT_DATA_WIDTH = 16
) (
  input  logic                         MSEQ_clk,
  input  logic                         MSEQ_rst_n,
  input  logic                         start,
  input  logic                         stop,
  input  logic [3:0]                   order,
  input  logic [15:0]                  chip_div,
  input  logic [OUTPUT_DATA_WIDTH-1:0] amp_hi,
  input  logic [OUTPUT_DATA_WIDTH-1:0] amp_lo,
  output logic [OUTPUT_DATA_WIDTH-1:0] MSEQ_signal,
  output logic                         chip_valid,
  output logic                         period_done,
  output logic                         busy,
  output logic                         cfg_err,
  output logic                         fsm_state
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state, state_next;
  logic   load, err_set, order_ok;

  logic [3:0]                   cfg_order;
  logic [15:0]                  cfg_div;
  logic [OUTPUT_DATA_WIDTH-1:0] cfg_hi, cfg_lo;

  logic [11:0] lfsr, lfsr_adv, seed, chip_max;
  logic [11:0] chip_cnt, chip_adv;
  logic [15:0] div_cnt;
  logic        chip_wrap;

  function automatic logic [11:0] len_mask(input logic [3:0] n);
    logic [12:0] full;
    full = (13'd1 << n) - 13'd1;
    return full[11:0];
  endfunction

  // Tap numbers are 1-based, so tap k reads s[k-1].
  function automatic logic tap_fb(input logic [11:0] s, input logic [3:0] n);
    case (n)
      4'd4:    tap_fb = s[3] ^ s[2];
      4'd5:    tap_fb = s[4] ^ s[2];
      4'd6:    tap_fb = s[5] ^ s[4];
      4'd7:    tap_fb = s[6] ^ s[5];
      4'd8:    tap_fb = s[7] ^ s[5] ^ s[4] ^ s[3];
      4'd9:    tap_fb = s[8] ^ s[4];
      4'd10:   tap_fb = s[9] ^ s[6];
      4'd11:   tap_fb = s[10] ^ s[8];
      4'd12:   tap_fb = s[11] ^ s[10] ^ s[9] ^ s[3];
      default: tap_fb = 1'b0;
    endcase
  endfunction

  function automatic logic out_bit(input logic [11:0] s, input logic [3:0] n);
    logic [11:0] sh;
    sh = s >> (n - 4'd1);
    return sh[0];
  endfunction

  assign seed      = len_mask(order);
  assign chip_max  = len_mask(cfg_order) - 12'd1;
  assign lfsr_adv  = ((lfsr << 1) | {11'd0, tap_fb(lfsr, cfg_order)}) & len_mask(cfg_order);
  assign chip_wrap = (div_cnt == cfg_div);
  assign chip_adv  = (chip_cnt == chip_max) ? 12'd0 : chip_cnt + 12'd1;
  assign order_ok  = (order >= 4'd4) && (order <= 4'd12);

  assign busy      = (state == RUN);
  assign fsm_state = state;

  always_ff @(posedge MSEQ_clk) begin
    if (!MSEQ_rst_n) state <= IDLE;
    else             state <= state_next;
  end

  // stop outranks start in IDLE; start is ignored while running.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          if (order_ok) begin
            load       = 1'b1;
            state_next = RUN;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      RUN:     if (stop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge MSEQ_clk) begin
    if (!MSEQ_rst_n) begin
      cfg_order   <= '0;
      cfg_div     <= '0;
      cfg_hi      <= '0;
      cfg_lo      <= '0;
      lfsr        <= '0;
      div_cnt     <= '0;
      chip_cnt    <= '0;
      MSEQ_signal <= '0;
      chip_valid  <= 1'b0;
      period_done <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      chip_valid  <= 1'b0;
      period_done <= 1'b0;
      if (load) begin
        cfg_order   <= order;
        cfg_div     <= chip_div;
        cfg_hi      <= amp_hi;
        cfg_lo      <= amp_lo;
        lfsr        <= seed;
        div_cnt     <= '0;
        chip_cnt    <= '0;
        cfg_err     <= 1'b0;
        chip_valid  <= 1'b1;
        MSEQ_signal <= out_bit(seed, order) ? amp_hi : amp_lo;
      end else if (state == RUN && state_next == RUN) begin
        if (chip_wrap) begin
          div_cnt     <= '0;
          lfsr        <= lfsr_adv;
          chip_cnt    <= chip_adv;
          chip_valid  <= 1'b1;
          period_done <= (chip_adv == chip_max);
          MSEQ_signal <= out_bit(lfsr_adv, cfg_order) ? cfg_hi : cfg_lo;
        end else begin
          div_cnt <= div_cnt + 16'd1;
        end
      end else begin
        MSEQ_signal <= '0;
        lfsr        <= '0;
        div_cnt     <= '0;
        chip_cnt    <= '0;
      end
      if (err_set) cfg_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mseq_generator.sv
// Directed bench for mseq_generator: hand-derived chip patterns, timing and control corner cases.
module tb_mseq_generator;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [3:0]   order = 4'd0;
  logic [15:0]  chip_div = 16'd0;
  logic [W-1:0] amp_hi = '0;
  logic [W-1:0] amp_lo = '0;
  logic [W-1:0] sig;
  logic         chip_valid, period_done, busy, cfg_err, fsm_state;

  int n_cmp = 0;
  int n_bad = 0;
  int ones;
  logic [W-1:0] exp_q[$];
  logic [14:0]  pat4 = 15'b111100010011010;
  logic [7:0]   pat7 = 8'b11111110;
  logic [8:0]   pat5 = 9'b111110001;

  mseq_generator #(.OUTPUT_DATA_WIDTH(W)) dut (
    .MSEQ_clk    (clk),
    .MSEQ_rst_n  (rst_n),
    .start       (start),
    .stop        (stop),
    .order       (order),
    .chip_div    (chip_div),
    .amp_hi      (amp_hi),
    .amp_lo      (amp_lo),
    .MSEQ_signal (sig),
    .chip_valid  (chip_valid),
    .period_done (period_done),
    .busy        (busy),
    .cfg_err     (cfg_err),
    .fsm_state   (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_sig"}, 32'(sig), 32'd0);
    check_val({tag, "_cv"}, 32'(chip_valid), 32'd0);
    check_val({tag, "_pd"}, 32'(period_done), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_state"}, 32'(fsm_state), 32'd0);
  endtask

  // Outputs settle after the posedge; all drives and checks happen at negedge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    check_idle("rst");
    check_val("rst_err", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_rst");

    // order 4, one chip per clock, three periods; mid-run input changes and a stray start
    order = 4'd4; chip_div = 16'd0; amp_hi = 16'h7FFF; amp_lo = 16'h8001;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 15; k++)
        exp_q.push_back(pat4[14-k] ? 16'h7FFF : 16'h8001);
    pulse_start();
    ones = 0;
    for (int i = 0; i < 45; i++) begin
      check_val("o4_sig", 32'(sig), 32'(exp_q.pop_front()));
      check_val("o4_cv", 32'(chip_valid), 32'd1);
      check_val("o4_pd", 32'(period_done), 32'((i % 15) == 14));
      check_val("o4_busy", 32'(busy), 32'd1);
      if (i < 15 && sig == 16'h7FFF) ones++;
      if (i == 10) start = 1'b1;
      if (i == 11) start = 1'b0;
      if (i == 20) begin
        order = 4'd9; chip_div = 16'd7; amp_hi = 16'h0000; amp_lo = 16'h0000;
      end
      @(negedge clk);
    end
    check_val("o4_ones", 32'(ones), 32'd8);
    pulse_stop();
    check_idle("o4_stop");

    // order 7, four clocks per chip
    order = 4'd7; chip_div = 16'd3; amp_hi = 16'h1111; amp_lo = 16'h2222;
    pulse_start();
    for (int i = 0; i < 1202; i++) begin
      check_val("o7_cv", 32'(chip_valid), 32'((i % 4) == 0));
      check_val("o7_pd", 32'(period_done), 32'((i % 508) == 504));
      if (i < 32)
        check_val("o7_sig", 32'(sig), pat7[7 - i/4] ? 32'h1111 : 32'h2222);
      else
        check_val("o7_amp", 32'(sig == 16'h1111 || sig == 16'h2222), 32'd1);
      @(negedge clk);
    end

    // stop mid-chip, then restart at order 5
    stop = 1'b1;
    order = 4'd5; chip_div = 16'd0; amp_hi = 16'h0A0A; amp_lo = 16'h0505;
    @(negedge clk);
    stop = 1'b0;
    check_idle("midstop");
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      check_val("o5_sig", 32'(sig), pat5[8-i] ? 32'h0A0A : 32'h0505);
      check_val("o5_cv", 32'(chip_valid), 32'd1);
      @(negedge clk);
    end
    pulse_stop();

    // order 12 full period
    order = 4'd12; chip_div = 16'd0; amp_hi = 16'h0001; amp_lo = 16'h0000;
    pulse_start();
    ones = 0;
    for (int i = 0; i < 4110; i++) begin
      check_val("o12_pd", 32'(period_done), 32'((i % 4095) == 4094));
      check_val("o12_cv", 32'(chip_valid), 32'd1);
      if (i < 4095 && sig == 16'h0001) ones++;
      @(negedge clk);
    end
    check_val("o12_ones", 32'(ones), 32'd2048);
    pulse_stop();

    // illegal orders set a sticky error; a legal start clears it
    order = 4'd3;
    pulse_start();
    check_val("err3", 32'(cfg_err), 32'd1);
    check_idle("err3");
    @(negedge clk);
    check_val("err3_sticky", 32'(cfg_err), 32'd1);
    order = 4'd13;
    pulse_start();
    check_val("err13", 32'(cfg_err), 32'd1);
    check_idle("err13");
    order = 4'd4; chip_div = 16'd0; amp_hi = 16'h7FFF; amp_lo = 16'h8001;
    pulse_start();
    check_val("err_clr", 32'(cfg_err), 32'd0);
    check_val("err_clr_busy", 32'(busy), 32'd1);
    check_val("err_clr_sig", 32'(sig), 32'h7FFF);

    // start and stop together in IDLE: stop wins
    pulse_stop();
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check_idle("both_idle");

    // reset mid-run overrides start and stop
    pulse_start();
    repeat (5) @(negedge clk);
    check_val("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    check_idle("midrst");
    check_val("midrst_err", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("midrst_both");
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    check_idle("midrst_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
